// File: rtl/bank_burst_ctrl.sv
// Burst sequencer: expands one read/write column command into BL single-beat
// bank accesses whose columns wrap inside the BL-aligned block.
module bank_burst_ctrl #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLS         = 1024,
    parameter int BL           = 8,
    parameter int CHWIDTH      = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_wr,
    input  logic [CHWIDTH-1:0]        cmd_row,
    input  logic [$clog2(COLS)-1:0]   cmd_col,
    input  logic [DEVICE_WIDTH-1:0]   wdata,
    input  logic                      wdata_valid,
    output logic                      wdata_ready,
    output logic [DEVICE_WIDTH-1:0]   rdata,
    output logic                      rdata_valid,
    output logic                      done,
    output logic [CHWIDTH-1:0]        bank_row,
    output logic [$clog2(COLS)-1:0]   bank_column,
    output logic                      bank_rd_o_wr,
    output logic [DEVICE_WIDTH-1:0]   bank_dqin,
    input  logic [DEVICE_WIDTH-1:0]   bank_dqout
);

    localparam int CW  = $clog2(COLS);
    localparam int LBL = $clog2(BL);
    localparam logic [CW-1:0]  OFF_MASK = CW'(BL - 1);
    localparam logic [LBL-1:0] LAST_IDX = LBL'(BL - 1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [CHWIDTH-1:0]      r_row;
    logic [CW-1:0]           r_base;
    logic [CW-1:0]           r_bank_col;
    logic [LBL-1:0]          r_off;
    logic [LBL-1:0]          r_cnt;
    logic [DEVICE_WIDTH-1:0] r_bank_dq;
    logic                    r_bank_we;
    logic                    r_rd_beat;
    logic                    r_rd_last;
    logic                    r_rvalid;
    logic                    r_done;

    logic                    w_cmd_ready;
    logic                    w_accept;
    logic                    w_issue;
    logic                    w_issue_wr;
    logic                    w_last;
    logic [LBL-1:0]          w_beat_idx;
    logic [CW-1:0]           w_beat_col;

    // LBL-bit sum wraps mod BL, keeping the beat inside its aligned block
    assign w_beat_idx = r_off + r_cnt;
    assign w_beat_col = r_base | CW'(w_beat_idx);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_issue_wr  = 1'b0;
        w_cmd_ready = (r_state == IDLE) && !rst;
        w_last      = (r_cnt == LAST_IDX);
        case (r_state)
            IDLE: begin
                if (cmd_valid && w_cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = cmd_wr ? WR : RD;
                end
            end
            RD: begin
                w_issue = 1'b1;
                if (w_last) w_state_nxt = IDLE;
            end
            WR: begin
                if (wdata_valid) begin
                    w_issue    = 1'b1;
                    w_issue_wr = 1'b1;
                    if (w_last) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Read beat 0 goes out on the accept edge so reads run BL cycles with no bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row      <= '0;
            r_base     <= '0;
            r_off      <= '0;
            r_cnt      <= '0;
            r_bank_col <= '0;
            r_bank_dq  <= '0;
            r_bank_we  <= 1'b0;
            r_rd_beat  <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_bank_we <= w_issue_wr;
            r_rd_beat <= (w_accept && !cmd_wr) || (w_issue && !w_issue_wr);
            r_rd_last <= w_issue && !w_issue_wr && w_last;
            r_rvalid  <= r_rd_beat;
            r_done    <= r_rd_last || (w_issue_wr && w_last);
            if (w_accept) begin
                r_row      <= cmd_row;
                r_base     <= cmd_col & ~OFF_MASK;
                r_off      <= cmd_col[LBL-1:0];
                r_cnt      <= cmd_wr ? '0 : LBL'(1);
                r_bank_col <= cmd_col;
            end else if (w_issue) begin
                r_bank_col <= w_beat_col;
                r_cnt      <= r_cnt + LBL'(1);
                if (w_issue_wr) r_bank_dq <= wdata;
            end
        end
    end

    assign cmd_ready    = w_cmd_ready;
    assign wdata_ready  = (r_state == WR);
    assign rdata        = bank_dqout;
    assign rdata_valid  = r_rvalid;
    assign done         = r_done;
    assign bank_row     = r_row;
    assign bank_column  = r_bank_col;
    assign bank_rd_o_wr = r_bank_we;
    assign bank_dqin    = r_bank_dq;

endmodule

// File: tb/tb_bank_burst_ctrl.sv
// Scoreboard bench for bank_burst_ctrl: driver pushes expected bank/read events,
// a negedge monitor pops and compares them against a behavioural bank model.
module tb_bank_burst_ctrl;

    localparam int DW   = 4;
    localparam int COLS = 1024;
    localparam int BL   = 8;
    localparam int CH   = 5;
    localparam int CW   = 10;
    localparam int ROWS = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [CH-1:0] cmd_row;
    logic [CW-1:0] cmd_col;
    logic [DW-1:0] wdata;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          done;
    logic [CH-1:0] bank_row;
    logic [CW-1:0] bank_column;
    logic          bank_rd_o_wr;
    logic [DW-1:0] bank_dqin;
    logic [DW-1:0] bank_dqout;

    always #5 clk = ~clk;

    bank_burst_ctrl #(
        .DEVICE_WIDTH(DW),
        .COLS        (COLS),
        .BL          (BL),
        .CHWIDTH     (CH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr      (cmd_wr),
        .cmd_row     (cmd_row),
        .cmd_col     (cmd_col),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .done        (done),
        .bank_row    (bank_row),
        .bank_column (bank_column),
        .bank_rd_o_wr(bank_rd_o_wr),
        .bank_dqin   (bank_dqin),
        .bank_dqout  (bank_dqout)
    );

    // Bank storage with fixed one-cycle read latency
    bit [DW-1:0] bank_mem [ROWS*COLS];
    always @(posedge clk) begin
        bank_dqout <= bank_mem[{bank_row, bank_column}];
        if (bank_rd_o_wr) bank_mem[{bank_row, bank_column}] <= bank_dqin;
    end

    typedef struct {
        int row;
        int col;
        int data;
        int cyc;
        bit last;
    } exp_t;

    exp_t q_rd[$];
    exp_t q_wr[$];
    int   model_mem [ROWS*COLS];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int n_done = 0;
    int n_done_exp = 0;
    int cur_row, cur_base, cur_off, last_accept;
    int wbuf [BL];
    int gaps [BL];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor
    logic [CH-1:0] prev_row;
    logic [CW-1:0] prev_col;
    logic          prev_we;
    exp_t          me;

    always @(negedge clk) begin
        if (done) n_done++;
        if (rdata_valid) begin
            if (q_rd.size() == 0) chk("rd_unexpected", int'(rdata_valid), 0);
            else begin
                me = q_rd.pop_front();
                chk("rd_addr", int'({prev_row, prev_col}), me.row * COLS + me.col);
                chk("rd_beat_is_read", int'(prev_we), 0);
                chk("rd_data", int'(rdata), me.data);
                chk("rd_cycle", cyc, me.cyc);
                chk("rd_done", int'(done), int'(me.last));
            end
        end
        if (bank_rd_o_wr) begin
            if (q_wr.size() == 0) chk("wr_unexpected", int'(bank_rd_o_wr), 0);
            else begin
                me = q_wr.pop_front();
                chk("wr_addr", int'({bank_row, bank_column}), me.row * COLS + me.col);
                chk("wr_data", int'(bank_dqin), me.data);
                chk("wr_cycle", cyc, me.cyc);
                chk("wr_done", int'(done), int'(me.last));
            end
        end
        if (done && !rdata_valid && !bank_rd_o_wr) chk("done_spurious", int'(done), 0);
        prev_row = bank_row;
        prev_col = bank_column;
        prev_we  = bank_rd_o_wr;
    end

    // Accept a command; beat i of the burst targets base + (off+i) mod BL
    task automatic issue_cmd(input bit wr, input int row, input int col);
        int budget;
        int a;
        int c;
        exp_t e;
        cmd_wr    = wr;
        cmd_row   = CH'(row);
        cmd_col   = CW'(col);
        cmd_valid = 1'b1;
        budget    = 0;
        @(negedge clk);
        while (!cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", int'(cmd_ready), 1);
            cmd_valid = 1'b0;
            return;
        end
        a           = cyc + 1;
        last_accept = a;
        cur_row     = row;
        cur_base    = col - (col % BL);
        cur_off     = col % BL;
        for (int i = 0; i < BL; i++) begin
            c = cur_base + (cur_off + i) % BL;
            if (wr) model_mem[row * COLS + c] = wbuf[i];
            else begin
                e.row  = row;
                e.col  = c;
                e.data = model_mem[row * COLS + c];
                e.cyc  = a + 1 + i;
                e.last = (i == BL - 1);
                q_rd.push_back(e);
            end
        end
        n_done_exp++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_wdata();
        int budget;
        exp_t e;
        for (int i = 0; i < BL; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                wdata_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            wdata       = DW'(wbuf[i]);
            wdata_valid = 1'b1;
            budget      = 0;
            @(negedge clk);
            while (!wdata_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (!wdata_ready) begin
                chk("wdata_timeout", int'(wdata_ready), 1);
                wdata_valid = 1'b0;
                return;
            end
            e.row  = cur_row;
            e.col  = cur_base + (cur_off + i) % BL;
            e.data = wbuf[i];
            e.cyc  = cyc + 1;
            e.last = (i == BL - 1);
            q_wr.push_back(e);
            @(posedge clk);
            #1;
        end
        wdata_valid = 1'b0;
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < BL; i++) gaps[i] = 0;
    endtask

    initial begin
        int a1;
        int a2;
        int t;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_wr      = 1'b0;
        cmd_row     = '0;
        cmd_col     = '0;
        wdata       = '0;
        wdata_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_wdata_ready", int'(wdata_ready), 0);
        chk("rst_bank_we", int'(bank_rd_o_wr), 0);
        chk("rst_bank_row", int'(bank_row), 0);
        chk("rst_bank_col", int'(bank_column), 0);
        chk("rst_bank_dqin", int'(bank_dqin), 0);
        chk("rst_rdata_valid", int'(rdata_valid), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        #1;
        chk("idle_cmd_ready", int'(cmd_ready), 1);

        // Preload row 3 cols 0..7 with 0..7, then wrapped read from col 5
        clear_gaps();
        for (int i = 0; i < BL; i++) wbuf[i] = i;
        issue_cmd(1'b1, 3, 0);
        cmd_valid = 1'b0;
        send_wdata();
        issue_cmd(1'b0, 3, 5);
        cmd_valid = 1'b0;
        chk("rd_first_col", int'(bank_column), 5);
        repeat (BL + 2) @(posedge clk);
        #1;

        // Write at the top column: wraps back to 0x3F8, then read it back
        for (int i = 0; i < BL; i++) wbuf[i] = 10 - i;
        issue_cmd(1'b1, 1, 'h3FF);
        cmd_valid = 1'b0;
        send_wdata();
        issue_cmd(1'b0, 1, 'h3F8);
        cmd_valid = 1'b0;
        repeat (BL + 2) @(posedge clk);
        #1;

        // Write with wdata_valid dropped before beats 2 and 5
        for (int i = 0; i < BL; i++) wbuf[i] = 15 - i;
        gaps[2] = 1;
        gaps[5] = 1;
        issue_cmd(1'b1, 2, 'h13);
        cmd_valid = 1'b0;
        send_wdata();
        clear_gaps();
        issue_cmd(1'b0, 2, 'h10);
        cmd_valid = 1'b0;
        repeat (BL + 2) @(posedge clk);
        #1;

        // Back-to-back read then write with cmd_valid held
        for (int i = 0; i < BL; i++) wbuf[i] = (3 * i + 1) % 16;
        issue_cmd(1'b0, 3, 5);
        a1 = last_accept;
        issue_cmd(1'b1, 4, 9);
        a2 = last_accept;
        cmd_valid = 1'b0;
        chk("b2b_accept_cycle", a2, a1 + BL);
        send_wdata();
        repeat (4) @(posedge clk);
        #1;

        // Reset during read beat 4: remaining beats are dropped, no done
        issue_cmd(1'b0, 3, 2);
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        q_rd.delete();
        n_done_exp--;
        chk("abort_rdata_valid", int'(rdata_valid), 0);
        chk("abort_bank_we", int'(bank_rd_o_wr), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_cmd_ready_in_rst", int'(cmd_ready), 0);
        rst = 1'b0;
        #1;
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        repeat (BL + 2) @(posedge clk);
        #1;

        // Randomised mix of reads and writes
        for (int k = 0; k < 60; k++) begin
            int wr;
            int row;
            int col;
            wr  = int'($urandom_range(0, 1));
            row = int'($urandom_range(0, 3));
            col = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, COLS - 1))
                                              : int'($urandom_range(0, 47));
            if (wr != 0) begin
                for (int i = 0; i < BL; i++) begin
                    wbuf[i] = int'($urandom_range(0, 15));
                    gaps[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                end
                issue_cmd(1'b1, row, col);
                cmd_valid = 1'b0;
                send_wdata();
            end else begin
                issue_cmd(1'b0, row, col);
                if ($urandom_range(0, 1) == 0) cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;

        t = 0;
        while ((q_rd.size() != 0 || q_wr.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_rd_queue", q_rd.size(), 0);
        chk("drain_wr_queue", q_wr.size(), 0);
        chk("done_count", n_done, n_done_exp);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
